// File: rtl/spart_driver_if.sv
// Processor-side SPART bus: one-cycle chip-select accesses over a shared
// tri-state byte lane, plus the SPART's rx-ready / tx-ready flags.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, inout databus, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, inout databus, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// Bus master standing in for a processor next to the SPART: programs the baud
// divisor from the switches, then echoes every received byte via a 4-deep FIFO.
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'h028A,
  parameter logic [15:0] DIV_9600  = 16'h0145,
  parameter logic [15:0] DIV_19200 = 16'h00A2,
  parameter logic [15:0] DIV_38400 = 16'h0050
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       br_cfg,
  output logic             cfg_valid,
  spart_driver_if.master   bus
);

  typedef enum logic [2:0] {
    CFG_LO, CFG_HI, IDLE, RD_RX, WR_TX, HOLD
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync1, r_br_sync, r_cfg_q;
  logic        r_cfg_valid;
  logic [7:0]  r_fifo [0:3];
  logic [1:0]  r_rd_ptr, r_wr_ptr;
  logic [2:0]  r_count;

  logic        w_iocs, w_iorw, w_drive;
  logic [1:0]  w_ioaddr;
  logic [7:0]  w_wdata;
  logic [15:0] w_div_now, w_div_cfg;

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_4800;
      2'b01:   return DIV_9600;
      2'b10:   return DIV_19200;
      default: return DIV_38400;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CFG_LO;
      r_sync1     <= 2'b00;
      r_br_sync   <= 2'b00;
      r_cfg_q     <= 2'b00;
      r_cfg_valid <= 1'b0;
      r_rd_ptr    <= 2'd0;
      r_wr_ptr    <= 2'd0;
      r_count     <= 3'd0;
    end else begin
      r_sync1   <= br_cfg;
      r_br_sync <= r_sync1;
      case (r_state)
        CFG_LO: begin
          r_cfg_q <= r_br_sync;
          r_state <= CFG_HI;
        end
        CFG_HI: begin
          r_cfg_valid <= 1'b1;
          r_state     <= IDLE;
        end
        IDLE: begin
          // Reconfiguration wins; reads beat writes so the SPART never overruns.
          if (r_br_sync != r_cfg_q) begin
            r_cfg_valid <= 1'b0;
            r_state     <= CFG_LO;
          end else if (bus.rda && (r_count < 3'd4)) begin
            r_state <= RD_RX;
          end else if (bus.tbr && (r_count != 3'd0)) begin
            r_state <= WR_TX;
          end
        end
        RD_RX: begin
          r_wr_ptr <= r_wr_ptr + 2'd1;
          r_count  <= r_count + 3'd1;
          r_state  <= HOLD;
        end
        WR_TX: begin
          r_rd_ptr <= r_rd_ptr + 2'd1;
          r_count  <= r_count - 3'd1;
          r_state  <= HOLD;
        end
        HOLD:    r_state <= IDLE;
        default: r_state <= CFG_LO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == RD_RX) r_fifo[r_wr_ptr] <= bus.databus;
  end

  // Bus is Moore-decoded from state, but rst releases it combinationally.
  always_comb begin
    w_div_now = div_of(r_br_sync);
    w_div_cfg = div_of(r_cfg_q);
    w_iocs    = 1'b0;
    w_iorw    = 1'b1;
    w_ioaddr  = 2'b00;
    w_drive   = 1'b0;
    w_wdata   = 8'h00;
    if (!rst) begin
      case (r_state)
        CFG_LO: begin
          w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b10;
          w_drive = 1'b1; w_wdata = w_div_now[7:0];
        end
        CFG_HI: begin
          w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b11;
          w_drive = 1'b1; w_wdata = w_div_cfg[15:8];
        end
        RD_RX: begin
          w_iocs = 1'b1; w_iorw = 1'b1; w_ioaddr = 2'b00;
        end
        WR_TX: begin
          w_iocs = 1'b1; w_iorw = 1'b0; w_ioaddr = 2'b00;
          w_drive = 1'b1; w_wdata = r_fifo[r_rd_ptr];
        end
        default: ;
      endcase
    end
  end

  assign bus.iocs    = w_iocs;
  assign bus.iorw    = w_iorw;
  assign bus.ioaddr  = w_ioaddr;
  assign bus.databus = w_drive ? w_wdata : 8'bz;
  assign cfg_valid   = r_cfg_valid;

endmodule
